// File: rtl/booth_seq_multiplier_pkg.sv
// Shared definitions for the sequential Booth multiplier.
//   state_t    : FSM states IDLE / RUN / DONE
//   cnt_width  : bit width of the step counter for a given operand width;
//                it must hold WIDTH+1, the number of Booth steps per operation.
package booth_seq_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_seq_multiplier_if.sv
// Request/result bundle of the sequential Booth multiplier.
//   start      : request, accepted only while busy==0
//   is_signed  : 1 = operands are two's complement, 0 = unsigned
//   M, Q       : multiplicand / multiplier, sampled on an accepted start
//   A          : 2*WIDTH-bit product, holds the last completed result
//   busy       : 1 while iterating
//   done       : one-cycle pulse, A carries a new result
//   state      : current FSM state, exported for observation
//
// Handshake: an operation is accepted on a rising clock edge where
// start==1 && busy==0 (IDLE or DONE). After acceptance the operand inputs
// may change freely; start while busy is ignored and not remembered.
// The result is announced by done==1 for exactly one cycle.
interface booth_seq_multiplier_if #(
    parameter int WIDTH = 8
);
    import booth_seq_multiplier_pkg::*;

    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     M;
    logic [WIDTH-1:0]     Q;
    logic [2*WIDTH-1:0]   A;
    logic                 busy;
    logic                 done;
    state_t               state;

    modport master (
        output start, is_signed, M, Q,
        input  A, busy, done, state
    );

    modport slave (
        input  start, is_signed, M, Q,
        output A, busy, done, state
    );

endinterface

// File: rtl/booth_seq_multiplier_step.sv
// One radix-2 Booth iteration (combinational).
//   acc, mq, q_m1, mcand : current accumulator, multiplier register,
//                          previous multiplier bit and multiplicand
//   acc_n, mq_n, q_m1_n  : values after the add/sub and the arithmetic
//                          right shift of {acc, mq, q_m1}
// IW is the internal width (operand width + 1), which keeps the add and
// subtract free of overflow for both signed and unsigned operands.
module booth_step #(
    parameter int IW = 9
) (
    input  logic [IW-1:0] acc,
    input  logic [IW-1:0] mq,
    input  logic          q_m1,
    input  logic [IW-1:0] mcand,
    output logic [IW-1:0] acc_n,
    output logic [IW-1:0] mq_n,
    output logic          q_m1_n
);

    logic [IW-1:0] sum;

    always_comb begin
        sum = acc;
        case ({mq[0], q_m1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc - mcand;
            default: sum = acc;
        endcase
        // Arithmetic shift right of the concatenation {sum, mq, q_m1}.
        acc_n  = {sum[IW-1], sum[IW-1:1]};
        mq_n   = {sum[0], mq[IW-1:1]};
        q_m1_n = mq[0];
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-2 Booth multiplier, one step per clock.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : slave side of booth_seq_multiplier_if (start, is_signed, M, Q,
//            A, busy, done, state)
// An accepted operation takes WIDTH+1 steps; DONE is entered on the edge
// that performs the final step, and A is written only at that moment.
module booth_seq_multiplier
    import booth_seq_multiplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    booth_seq_multiplier_if.slave   bus
);

    localparam int            IW    = WIDTH + 1;
    localparam int            CW    = cnt_width(WIDTH);
    localparam logic [CW-1:0] STEPS = CW'(IW);

    state_t               state;
    state_t               next_state;
    logic [IW-1:0]        acc;
    logic [IW-1:0]        mq;
    logic [IW-1:0]        mcand;
    logic                 q_m1;
    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   prod;

    logic [IW-1:0]        acc_n;
    logic [IW-1:0]        mq_n;
    logic                 q_m1_n;

    logic                 accept;
    logic                 last_step;

    assign accept    = bus.start && (state != RUN);
    assign last_step = (state == RUN) && (count == CW'(1));

    booth_step #(.IW(IW)) u_step (
        .acc    (acc),
        .mq     (mq),
        .q_m1   (q_m1),
        .mcand  (mcand),
        .acc_n  (acc_n),
        .mq_n   (mq_n),
        .q_m1_n (q_m1_n)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = RUN;
            RUN:     if (count == CW'(1)) next_state = DONE;
            DONE:    next_state = bus.start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy  = (state == RUN);
        bus.done  = (state == DONE);
        bus.A     = prod;
        bus.state = state;
    end

    // Datapath: operand load, Booth iteration, result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            mq    <= '0;
            mcand <= '0;
            q_m1  <= 1'b0;
            count <= '0;
            prod  <= '0;
        end else if (accept) begin
            acc   <= '0;
            mq    <= {bus.is_signed & bus.Q[WIDTH-1], bus.Q};
            mcand <= {bus.is_signed & bus.M[WIDTH-1], bus.M};
            q_m1  <= 1'b0;
            count <= STEPS;
        end else if (state == RUN) begin
            acc   <= acc_n;
            mq    <= mq_n;
            q_m1  <= q_m1_n;
            count <= count - CW'(1);
            // Low 2*WIDTH bits of {acc, mq} after the final step.
            if (last_step) prod <= {acc_n[WIDTH-2:0], mq_n};
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier: WIDTH=4 directed table and
// corner sequences, WIDTH=8 random sweep against an arithmetic model.
module tb_booth_seq_multiplier;
    import booth_seq_multiplier_pkg::*;

    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    booth_seq_multiplier_if #(.WIDTH(4)) b4 ();
    booth_seq_multiplier_if #(.WIDTH(8)) b8 ();

    booth_seq_multiplier #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    booth_seq_multiplier #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer multiply per signedness, truncated to 16 bits.
    function automatic logic [15:0] ref_mul8(input logic s, input logic [7:0] m, input logic [7:0] q);
        int a;
        int b;
        if (s) begin
            a = int'($signed(m));
            b = int'($signed(q));
        end else begin
            a = int'(m);
            b = int'(q);
        end
        return 16'(a * b);
    endfunction

    // ---------------- drivers (called at #1 after an edge) ----------------
    task automatic accept4(input logic s, input logic [3:0] m, input logic [3:0] q);
        b4.is_signed = s;
        b4.M         = m;
        b4.Q         = q;
        b4.start     = 1'b1;
        @(posedge clk); #1;
        b4.start     = 1'b0;
    endtask

    task automatic wait_done4(output int lat);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            lat++;
            if (b4.done) break;
        end
    endtask

    task automatic op8(input logic s, input logic [7:0] m, input logic [7:0] q,
                       output logic [15:0] a, output int lat);
        b8.is_signed = s;
        b8.M         = m;
        b8.Q         = q;
        b8.start     = 1'b1;
        @(posedge clk); #1;
        b8.start     = 1'b0;
        // Scramble operands after accept; must not affect the result.
        b8.M         = 8'($urandom);
        b8.Q         = 8'($urandom);
        b8.is_signed = 1'($urandom);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            lat++;
            if (b8.done) break;
        end
        a = b8.A;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       s;
        logic [3:0] m;
        logic [3:0] q;
        logic [7:0] exp_a;
    } vec_t;

    vec_t vecs[6];

    logic [15:0] exp_q[$];

    initial begin
        int          lat;
        logic [15:0] a8;
        logic [15:0] e8;
        logic        s;
        logic [7:0]  m8;
        logic [7:0]  q8;

        vecs[0] = '{1'b1, 4'b0010, 4'b0011, 8'h06};
        vecs[1] = '{1'b1, 4'b0011, 4'b1001, 8'hEB};
        vecs[2] = '{1'b0, 4'b0011, 4'b1001, 8'h1B};
        vecs[3] = '{1'b1, 4'b1000, 4'b1000, 8'h40};
        vecs[4] = '{1'b0, 4'b1111, 4'b1111, 8'hE1};
        vecs[5] = '{1'b1, 4'b0000, 4'b0101, 8'h00};

        b4.start = 1'b0; b4.is_signed = 1'b0; b4.M = '0; b4.Q = '0;
        b8.start = 1'b0; b8.is_signed = 1'b0; b8.M = '0; b8.Q = '0;

        // ---- reset ----
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_A4",     32'(b4.A), 32'h0);
        chk("rst_busy4",  32'(b4.busy), 32'h0);
        chk("rst_done4",  32'(b4.done), 32'h0);
        chk("rst_state4", 32'(b4.state), 32'(IDLE));
        chk("rst_A8",     32'(b8.A), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- table ----
        foreach (vecs[i]) begin
            accept4(vecs[i].s, vecs[i].m, vecs[i].q);
            chk($sformatf("busy_after_accept[%0d]", i), 32'(b4.busy), 32'h1);
            wait_done4(lat);
            chk($sformatf("latency[%0d]", i), 32'(lat), 32'd5);
            chk($sformatf("A[%0d]", i), 32'(b4.A), 32'(vecs[i].exp_a));
            @(posedge clk); #1;
            chk($sformatf("done_pulse[%0d]", i), 32'(b4.done), 32'h0);
            chk($sformatf("A_hold[%0d]", i), 32'(b4.A), 32'(vecs[i].exp_a));
        end

        // ---- start while busy is ignored ----
        accept4(1'b1, 4'b0000, 4'b0101);
        b4.start = 1'b1; b4.M = 4'b0111; b4.Q = 4'b0111;
        @(posedge clk); #1;
        chk("ign_busy1", 32'(b4.busy), 32'h1);
        @(posedge clk); #1;
        chk("ign_busy2", 32'(b4.busy), 32'h1);
        chk("ign_A_mid", 32'(b4.A), 32'h00);
        b4.start = 1'b0;
        wait_done4(lat);
        chk("ign_latency", 32'(lat), 32'd3);
        chk("ign_A", 32'(b4.A), 32'h00);
        @(posedge clk); #1;
        chk("ign_idle", 32'(b4.busy | b4.done), 32'h0);

        // ---- back-to-back through DONE ----
        accept4(1'b1, 4'b0010, 4'b0011);
        wait_done4(lat);
        chk("b2b_lat1", 32'(lat), 32'd5);
        chk("b2b_done1", 32'(b4.done), 32'h1);
        chk("b2b_A1", 32'(b4.A), 32'h06);
        b4.start = 1'b1; b4.is_signed = 1'b1; b4.M = 4'b0101; b4.Q = 4'b0010;
        @(posedge clk); #1;
        b4.start = 1'b0;
        chk("b2b_busy2", 32'(b4.busy), 32'h1);
        chk("b2b_done_low", 32'(b4.done), 32'h0);
        chk("b2b_A_kept", 32'(b4.A), 32'h06);
        wait_done4(lat);
        chk("b2b_lat2", 32'(lat), 32'd5);
        chk("b2b_A2", 32'(b4.A), 32'h0A);
        @(posedge clk); #1;

        // ---- reset mid-RUN ----
        accept4(1'b1, 4'b0011, 4'b1001);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mrst_busy", 32'(b4.busy), 32'h0);
        chk("mrst_done", 32'(b4.done), 32'h0);
        chk("mrst_A", 32'(b4.A), 32'h0);
        @(posedge clk); #1;
        chk("mrst_still_idle", 32'(b4.busy | b4.done), 32'h0);
        accept4(1'b1, 4'b0010, 4'b0011);
        wait_done4(lat);
        chk("mrst_lat", 32'(lat), 32'd5);
        chk("mrst_A_new", 32'(b4.A), 32'h06);
        @(posedge clk); #1;

        // ---- WIDTH=8 sweep ----
        for (int i = 0; i < 43; i++) begin
            if (i == 0) begin
                s = 1'b1; m8 = 8'h80; q8 = 8'h80;
            end else if (i == 1) begin
                s = 1'b0; m8 = 8'hFF; q8 = 8'hFF;
            end else if (i == 2) begin
                s = 1'b1; m8 = 8'h7F; q8 = 8'h80;
            end else begin
                s  = 1'($urandom_range(0, 1));
                m8 = 8'($urandom_range(0, 255));
                q8 = 8'($urandom_range(0, 255));
            end
            exp_q.push_back(ref_mul8(s, m8, q8));
            op8(s, m8, q8, a8, lat);
            chk($sformatf("w8_lat[%0d]", i), 32'(lat), 32'd9);
            e8 = exp_q.pop_front();
            chk($sformatf("w8_A[%0d] s=%0d m=%0h q=%0h", i, s, m8, q8), 32'(a8), 32'(e8));
            @(posedge clk); #1;
        end
        chk("w8_min_square", 32'(ref_mul8(1'b1, 8'h80, 8'h80)), 32'h4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
